// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Optional MADD/MSUB (MDOp 110/111) are compiled in when MDU_MADD_EN is defined.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic        Cancel,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        MDM_Sel,
    output logic        Busy,
    output logic [31:0] MDOut,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] p_hi, p_lo;
    logic        p_we;

    logic        launch, commit;
    logic        op_valid, op_is_div;
    logic        mthi_we, mtlo_we;
    logic [63:0] res;
    logic        res_we;

    logic [63:0] prod_s, prod_u;
    logic [63:0] acc;
    logic [31:0] a_mag, b_mag, b_mag_nz, b_nz;
    logic [31:0] sq_mag, sr_mag, s_quo, s_rem;
    logic [31:0] u_quo, u_rem;
    logic        div_zero;

    assign acc    = {HI, LO};
    assign prod_s = $signed({{32{SrcA[31]}}, SrcA}) * $signed({{32{SrcB[31]}}, SrcB});
    assign prod_u = {32'b0, SrcA} * {32'b0, SrcB};

    // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0
    assign div_zero = (SrcB == '0);
    assign a_mag    = SrcA[31] ? -SrcA : SrcA;
    assign b_mag    = SrcB[31] ? -SrcB : SrcB;
    assign b_mag_nz = div_zero ? 32'd1 : b_mag;
    assign b_nz     = div_zero ? 32'd1 : SrcB;
    assign sq_mag   = a_mag / b_mag_nz;
    assign sr_mag   = a_mag % b_mag_nz;
    assign s_quo    = (SrcA[31] ^ SrcB[31]) ? -sq_mag : sq_mag;
    assign s_rem    = SrcA[31] ? -sr_mag : sr_mag;
    assign u_quo    = SrcA / b_nz;
    assign u_rem    = SrcA % b_nz;

    always_comb begin
        res       = '0;
        res_we    = 1'b1;
        op_valid  = 1'b0;
        op_is_div = 1'b0;
        case (MDOp)
            3'b000: begin res = prod_s; op_valid = 1'b1; end
            3'b001: begin res = prod_u; op_valid = 1'b1; end
            3'b010: begin
                res       = {s_rem, s_quo};
                res_we    = ~div_zero;
                op_valid  = 1'b1;
                op_is_div = 1'b1;
            end
            3'b011: begin
                res       = {u_rem, u_quo};
                res_we    = ~div_zero;
                op_valid  = 1'b1;
                op_is_div = 1'b1;
            end
`ifdef MDU_MADD_EN
            3'b110: begin res = acc + prod_s; op_valid = 1'b1; end
            3'b111: begin res = acc - prod_s; op_valid = 1'b1; end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        launch  = 1'b0;
        commit  = 1'b0;
        mthi_we = 1'b0;
        mtlo_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (!Cancel) begin
                    mthi_we = (MDOp == 3'b100);
                    mtlo_we = (MDOp == 3'b101);
                    if (Start && op_valid) begin
                        launch  = 1'b1;
                        state_d = BUSY;
                        cnt_d   = op_is_div ? DIV_LOAD : MULT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_hi <= '0;
            p_lo <= '0;
            p_we <= 1'b0;
            HI   <= '0;
            LO   <= '0;
        end else begin
            if (launch) begin
                p_hi <= res[63:32];
                p_lo <= res[31:0];
                p_we <= res_we;
            end
            if (commit) begin
                if (p_we) begin
                    HI <= p_hi;
                    LO <= p_lo;
                end
            end else if (mthi_we) begin
                HI <= SrcA;
            end else if (mtlo_we) begin
                LO <= SrcA;
            end
        end
    end

    assign Busy  = (state_q == BUSY);
    assign MDOut = MDM_Sel ? LO : HI;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (default MULT_CYCLES=5, DIV_CYCLES=10).
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic        Cancel;
    logic [31:0] SrcA, SrcB;
    logic        MDM_Sel;
    logic        Busy;
    logic [31:0] MDOut, HI, LO;

    int n_cmp = 0;
    int n_err = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .Cancel(Cancel),
        .SrcA(SrcA), .SrcB(SrcB), .MDM_Sel(MDM_Sel),
        .Busy(Busy), .MDOut(MDOut), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        check({tag, "_hi"}, 64'(HI), 64'(exp_hi));
        check({tag, "_lo"}, 64'(LO), 64'(exp_lo));
        MDM_Sel = 1'b0; #1;
        check({tag, "_mdout_hi"}, 64'(MDOut), 64'(exp_hi));
        MDM_Sel = 1'b1; #1;
        check({tag, "_mdout_lo"}, 64'(MDOut), 64'(exp_lo));
    endtask

    // Drives one request through one sampling edge; ends #1 after that edge.
    task automatic issue(input logic st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = st; MDOp = op; SrcA = a; SrcB = b;
        @(posedge clk); #1;
        Start = 1'b0; MDOp = 3'b000;
    endtask

    task automatic wait_idle(input string tag, input int exp_cycles);
        int n = 0;
        while (Busy && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'(exp_cycles));
    endtask

    initial begin
        reset = 1'b0; Start = 1'b0; MDOp = 3'b000; Cancel = 1'b0;
        SrcA = '0; SrcB = '0; MDM_Sel = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(Busy), 64'd0);
        check_hilo("reset", 32'h0, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        issue(1'b0, 3'b101, 32'h12345678, 32'h0);
        check_hilo("mtlo", 32'h0, 32'h12345678);
        issue(1'b0, 3'b100, 32'hCAFEBABE, 32'h0);
        check_hilo("mthi", 32'hCAFEBABE, 32'h12345678);

        issue(1'b1, 3'b000, 32'hFFFFFFFE, 32'h00000003);
        wait_idle("mult", 5);
        check_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);

        issue(1'b1, 3'b001, 32'hFFFFFFFE, 32'h00000003);
        wait_idle("multu", 5);
        check_hilo("multu", 32'h00000002, 32'hFFFFFFFA);

        issue(1'b1, 3'b010, 32'hFFFFFFF9, 32'h00000002);
        wait_idle("div", 10);
        check_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

        issue(1'b1, 3'b011, 32'h00000007, 32'h00000000);
        wait_idle("divu_zero", 10);
        check_hilo("divu_zero", 32'hFFFFFFFF, 32'hFFFFFFFD);

        issue(1'b1, 3'b010, 32'h80000000, 32'hFFFFFFFF);
        wait_idle("div_ovf", 10);
        check_hilo("div_ovf", 32'h00000000, 32'h80000000);

        issue(1'b1, 3'b011, 32'd100, 32'd7);
        wait_idle("divu", 10);
        check_hilo("divu", 32'd2, 32'd14);

        // DIV 100 / -7 with a MULT launch on Busy cycle 3 and an MTHI on cycle 4
        issue(1'b1, 3'b010, 32'd100, 32'hFFFFFFF9);
        @(posedge clk); #1;
        @(posedge clk); #1;
        issue(1'b1, 3'b000, 32'd2, 32'd2);
        issue(1'b0, 3'b100, 32'h0000DEAD, 32'h0);
        check("ignored_busy", 64'(Busy), 64'd1);
        wait_idle("ignored", 6);
        check_hilo("ignored", 32'd2, 32'hFFFFFFF2);

        Cancel = 1'b1;
        issue(1'b1, 3'b000, 32'd3, 32'd3);
        check("cancel_start_busy", 64'(Busy), 64'd0);
        issue(1'b0, 3'b100, 32'h11111111, 32'h0);
        Cancel = 1'b0;
        check_hilo("cancel", 32'd2, 32'hFFFFFFF2);

`ifdef MDU_MADD_EN
        issue(1'b0, 3'b100, 32'd0, 32'h0);
        issue(1'b0, 3'b101, 32'd10, 32'h0);
        issue(1'b1, 3'b110, 32'd3, 32'd4);
        wait_idle("madd", 5);
        check_hilo("madd", 32'd0, 32'd22);
        issue(1'b1, 3'b111, 32'd5, 32'd5);
        wait_idle("msub", 5);
        check_hilo("msub", 32'hFFFFFFFF, 32'hFFFFFFFD);
`else
        issue(1'b1, 3'b110, 32'd3, 32'd4);
        check("op110_busy", 64'(Busy), 64'd0);
        issue(1'b1, 3'b111, 32'd5, 32'd5);
        check("op111_busy", 64'(Busy), 64'd0);
        check_hilo("op11x", 32'd2, 32'hFFFFFFF2);
`endif

        // Reset asserted during the 4th Busy cycle of a MULT
        issue(1'b1, 3'b000, 32'd6, 32'd7);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("midrst_pre_busy", 64'(Busy), 64'd1);
        reset = 1'b0; #1;
        check("midrst_busy", 64'(Busy), 64'd0);
        check_hilo("midrst", 32'h0, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("midrst_after_busy", 64'(Busy), 64'd0);
        check_hilo("midrst_after", 32'h0, 32'h0);

        issue(1'b1, 3'b001, 32'd6, 32'd7);
        wait_idle("post_rst_multu", 5);
        check_hilo("post_rst_multu", 32'd0, 32'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit in the execute stage of the pipelined MIPS core. It accepts `Start`, `MDOp` and `MDM_Sel` from the pipeline control unit. It runs multi-cycle MULT/MULTU/DIV/DIVU operations on the E-stage operands, holds the HI/LO registers, and applies MTHI/MTLO writes. It reports `Busy` so the control unit stalls MD-class instructions in D until the result is committed.

## Interface
- `MULT_CYCLES`, 5, Busy cycles for MULT/MULTU (and MADD/MSUB when enabled); legal range 1..15
- `DIV_CYCLES`, 10, Busy cycles for DIV/DIVU; legal range 1..15
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted at 0)
- `Start`  in  1  E-stage multiply/divide launch strobe, one cycle per instruction
- `MDOp`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x see Configuration
- `Cancel`  in  1  exception/interrupt flush of the E-stage instruction; when 1, suppresses `Start` and MTHI/MTLO writes in the same cycle
- `SrcA`  in  32  forwarded rs value
- `SrcB`  in  32  forwarded rt value
- `MDM_Sel`  in  1  read select: 0 HI, 1 LO
- `Busy`  out  1  operation in flight
- `MDOut`  out  32  `MDM_Sel ? LO : HI` (combinational from registers)
- `HI`, `LO`  out  32 each  architectural registers

## Operation
- State: IDLE/BUSY, 4-bit down-counter `cnt`, 32-bit pending registers `pHI`/`pLO`.
- IDLE, `Start=1`, `Cancel=0`, MDOp 0xx:
  - compute the result from `SrcA`/`SrcB` and latch it into pHI/pLO;
  - load `cnt` with N−1, where N = `MULT_CYCLES` or `DIV_CYCLES`;
  - go to BUSY.
- BUSY: `cnt` decrements each cycle. On the edge where `cnt==0`, pHI/pLO are written to HI/LO and the state returns to IDLE.
- MULT: HI:LO = signed 64-bit `SrcA*SrcB`. MULTU: the same, unsigned.
- DIV: LO = signed quotient (truncated toward zero), HI = remainder with the sign of the dividend. DIVU: unsigned quotient and remainder.
- Divide by zero (`SrcB==0`): full Busy duration still applies, then HI/LO are left unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO: in IDLE with `Cancel=0`, HI (100) or LO (101) takes `SrcA` at the edge. No Busy is raised. `Start` is ignored for these codes.
- Requests that are ignored with no state change:
  - `Start` while BUSY;
  - MTHI/MTLO while BUSY;
  - `Cancel=1`;
  - MDOp 11x when `MDU_MADD_EN` is undefined.
- `reset=0` at any time, including mid-operation: immediately forces IDLE, `cnt=0`, Busy=0, HI=LO=pHI=pLO=0. The in-flight result is discarded.

## Timing
- Reset values: Busy=0, HI=0, LO=0, MDOut=0.
- `Start` sampled at edge T. Busy is 1 from just after T through edge T+N (exactly N cycles high). HI/LO are updated at edge T+N, and Busy falls at the same edge.
- A new `Start` is accepted at edge T+N+1 at the earliest. Back-to-back operations are therefore separated by at least N+1 cycles.
- MTHI/MTLO: the new value is visible on HI/LO/MDOut one cycle after the sampling edge.
- MDOut is read-after-commit only. The control unit stalls MFHI/MFLO while `Busy|Start_E`, so the block needs no bypass.

## Configuration
- `MDU_MADD_EN` defined: MDOp 110 = MADD, HI:LO += signed(`SrcA*SrcB`); 111 = MSUB, HI:LO −= signed(`SrcA*SrcB`).
  - Both are launched by `Start`, last `MULT_CYCLES`, and wrap modulo 2^64.
  - The accumulate base is the HI:LO value at the `Start` edge.
- Undefined: 11x is ignored, with no Busy and no state change.

## Test plan
- Reset: hold `reset=0` for 2 cycles, release → Busy=0, HI=LO=0. Then MTLO `SrcA=0x12345678` → next cycle LO=0x12345678, `MDOut`(`MDM_Sel=1`)=0x12345678.
- MULT 0xFFFFFFFE × 0x00000003 → Busy high exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (−7) ÷ 2 → Busy high 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 ÷ 0 → HI/LO unchanged after 10 cycles.
- Ignored requests: `Start` (MULT 2×2) asserted on the 3rd Busy cycle of a DIV, and MTHI during Busy → neither affects state; DIV result is intact. `Cancel=1` with `Start` → Busy stays 0.
- Mid-operation reset: `reset=0` on the 4th Busy cycle of a MULT → Busy=0, HI=LO=0 immediately, and nothing is committed afterward.
- With `MDU_MADD_EN`: HI:LO=0:10, MADD 3×4 → LO=22, HI=0; then MSUB 5×5 → HI=0xFFFFFFFF, LO=0xFFFFFFFD.
